fetch_queue_stage: RTL
======================

Name: fetch_queue_stage

Overview:
Parametrised instruction-fetch front end with a decoupled instruction queue. It replaces the fixed combinational-IMEM fetch stage and its IF/ID register.
- The PC register issues requests to an instruction memory over a req/gnt/rvalid handshake. Responses return in order with variable latency.
- Returned instructions are buffered with their PC and PC+4 in a DEPTH-entry queue.
- The queue feeds decode through a valid/ready handshake. Redirects from branch resolution flush the queue and squash in-flight responses.

Parameters:
XLEN, 32, PC/address width (>=16).
DEPTH, 4, instruction queue entries; power of two, >=2; also the cap on outstanding requests.
RESET_PC, 32'h0000_0000, PC value after reset (XLEN bits, bits[1:0]=0).
NOP_INST, 32'h0000_0013, instruction presented when queue empty (addi x0,x0,0).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset; synchronous, active-low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address (= current PC)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (in order)
imem_rdata_i  in  32  response instruction
redirect_i  in  1  flush and load new PC
redirect_pc_i  in  XLEN  redirect target
id_valid_o  out  1  queue head valid
id_ready_i  in  1  decode accepts head (low = stall)
id_inst_o  out  32  head instruction; NOP_INST when !id_valid_o
id_pc_o  out  XLEN  head PC; 0 when empty
id_pc_four_o  out  XLEN  head PC+4; 0 when empty
fq_count_o  out  $clog2(DEPTH)+1  queue occupancy
pc_debug_o  out  XLEN  current fetch PC

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - PC=RESET_PC; occupancy, outstanding count and drop count all 0.
  - imem_req_o=0, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0, id_pc_four_o=0.
  - Reset mid-transaction abandons all in-flight requests. Responses arriving while rst_ni=0 are ignored. The IMEM must not return responses for pre-reset requests after reset deasserts.
- Credit rule: imem_req_o = !redirect_i && (fq_count + outstanding < DEPTH). The queue therefore can never overflow.
- Issue:
  - On imem_req_o && imem_gnt_i: PC <= PC+4 (mod 2^XLEN, wraps silently); outstanding +1; PC is pushed into an internal pending-address FIFO of DEPTH entries.
  - While req is high and gnt is low, imem_addr_o holds stable.
- Response (imem_rvalid_i):
  - Pops the pending-address FIFO and decrements outstanding.
  - If drop count is 0: push {pc, pc+4, rdata} into the queue.
  - If drop count is >0: discard the response and decrement drop count.
  - Latency is 1 cycle: rvalid at edge N gives id_valid_o after edge N. There is no combinational bypass.
- Pop: on id_valid_o && id_ready_i, the head is removed at the edge.
- Push and pop in the same cycle leaves occupancy unchanged. Rvalid and gnt in the same cycle leaves outstanding unchanged.
- Stall: with id_ready_i=0 the head and all id_* outputs hold. Issue continues until credits are exhausted.
- Redirect (highest priority, single cycle):
  - PC <= {redirect_pc_i[XLEN-1:2],2'b00}.
  - Queue cleared (occupancy 0 next cycle); a pop in the same cycle is ignored.
  - No request issues this cycle.
  - drop count <= outstanding - (imem_rvalid_i ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - Back-to-back redirects: the latest target wins. Drop count is recomputed from the current outstanding count each time.
- Fetching from the new PC starts the cycle after a redirect. Its responses are enqueued only once all older responses have been dropped.
- pc_debug_o = PC register; imem_addr_o = PC register.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_redirect_cnt_o[31:0], both reset to 0 and wrapping at 2^32.
  - perf_stall_cnt_o increments each cycle id_valid_o && !id_ready_i.
  - perf_redirect_cnt_o increments each cycle redirect_i=1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, IMEM gnt=1 with fixed 1-cycle response latency, id_ready=1 -> addresses 0x0,0x4,0x8... issued; id_pc_o=0x0, id_pc_four_o=0x4, id_inst_o=mem[0] two cycles after first grant; one instruction per cycle thereafter.
2. id_ready=0 held 10 cycles -> fq_count_o saturates at 4; exactly 4 grants accepted, then imem_req_o=0; head stays 0x0; on release, queue drains in order 0x0,0x4,0x8,0xC.
3. Three requests outstanding (response latency 3), redirect_i=1 with redirect_pc_i=0x103 -> next imem_addr_o=0x100; the 3 old responses are discarded; first id_pc_o=0x100.
4. redirect_i and imem_rvalid_i in the same cycle, outstanding=1 -> drop count 0; that response is not enqueued; next enqueued PC = redirect target.
5. rst_ni=0 for one cycle while the queue holds 3 entries -> next cycle fq_count_o=0, id_valid_o=0, id_inst_o=0x00000013, imem_addr_o=RESET_PC.
6. PC=0xFFFF_FFFC granted -> next imem_addr_o=0x0000_0000; queued id_pc_four_o=0x0000_0000.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: PC issue over req/gnt/rvalid, in-order response
// tracking, and a DEPTH-entry decode queue. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_queue_stage #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter logic [31:0]          NOP_INST = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [31:0]                imem_rdata_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [31:0]                id_inst_o,
    output logic [XLEN-1:0]            id_pc_o,
    output logic [XLEN-1:0]            id_pc_four_o,
    output logic [$clog2(DEPTH):0]     fq_count_o,
    output logic [XLEN-1:0]            pc_debug_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_stall_cnt_o,
    output logic [31:0]                perf_redirect_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_pc;

    logic [31:0]     r_q_inst [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [XLEN-1:0] r_q_pc4  [DEPTH];
    logic [AW-1:0]   r_q_head;
    logic [AW-1:0]   r_q_tail;
    logic [CW-1:0]   r_q_count;

    logic [XLEN-1:0] r_pend_addr [DEPTH];
    logic [AW-1:0]   r_pend_rd;
    logic [AW-1:0]   r_pend_wr;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;

    logic [CW:0]     w_inflight;
    logic            w_req;
    logic            w_issue;
    logic            w_resp;
    logic            w_push;
    logic            w_valid;
    logic            w_pop;
    logic [XLEN-1:0] w_resp_pc;
    logic            w_unused_pc_lsb;

    // Queued entries plus outstanding requests never exceed DEPTH, so the queue cannot overflow.
    assign w_inflight = {1'b0, r_q_count} + {1'b0, r_outst};
    assign w_req      = !redirect_i && (w_inflight < (CW+1)'(DEPTH));
    assign w_issue    = w_req && imem_gnt_i;
    assign w_resp     = imem_rvalid_i && (r_outst != '0);
    assign w_push     = w_resp && !redirect_i && (r_drop == '0);
    assign w_valid    = (r_q_count != '0);
    assign w_pop      = w_valid && id_ready_i && !redirect_i;
    assign w_resp_pc  = r_pend_addr[r_pend_rd];

    assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign pc_debug_o   = r_pc;
    assign fq_count_o   = r_q_count;
    assign id_valid_o   = w_valid;
    assign id_inst_o    = w_valid ? r_q_inst[r_q_head] : NOP_INST;
    assign id_pc_o      = w_valid ? r_q_pc[r_q_head]   : '0;
    assign id_pc_four_o = w_valid ? r_q_pc4[r_q_head]  : '0;

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_pend_addr[r_pend_wr] <= r_pc;
        end
        if (w_push) begin
            r_q_inst[r_q_tail] <= imem_rdata_i;
            r_q_pc[r_q_tail]   <= w_resp_pc;
            r_q_pc4[r_q_tail]  <= w_resp_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc      <= RESET_PC;
            r_q_head  <= '0;
            r_q_tail  <= '0;
            r_q_count <= '0;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
            r_outst   <= '0;
            r_drop    <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_issue) - CW'(w_resp);
            if (w_issue) begin
                r_pend_wr <= r_pend_wr + AW'(1);
            end
            if (w_resp) begin
                r_pend_rd <= r_pend_rd + AW'(1);
            end
            if (redirect_i) begin
                // Every response still owed, minus one landing this cycle, belongs to the old path.
                r_pc      <= {redirect_pc_i[XLEN-1:2], 2'b00};
                r_q_head  <= '0;
                r_q_tail  <= '0;
                r_q_count <= '0;
                r_drop    <= r_outst - CW'(w_resp);
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (w_resp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_q_tail <= r_q_tail + AW'(1);
                end
                if (w_pop) begin
                    r_q_head <= r_q_head + AW'(1);
                end
                r_q_count <= r_q_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_perf_stall    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (w_valid && !id_ready_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_i) begin
                r_perf_redirect <= r_perf_redirect + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o    = r_perf_stall;
    assign perf_redirect_cnt_o = r_perf_redirect;
`endif

endmodule
